// File: rtl/clock_pkg.sv
// Shared types and field widths for the digital clock time-keeping path.
package clock_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2
   } clk_mode_t;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int SEC_W  = 6;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with synchronous clear and a combinational wrap carry.
module mod_counter #(
   parameter int WIDTH = 6,
   parameter int MOD   = 60
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clear,
   output logic [WIDTH-1:0] value,
   output logic             carry
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] value_d;

   // Wrap is decided by comparing against MOD-1 first, so the add never overflows.
   always_comb begin
      value_d = value_q;
      if (clear) begin
         value_d = '0;
      end else if (inc) begin
         value_d = (value_q == LAST) ? '0 : value_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;
   assign carry = inc && (value_q == LAST);

endmodule

// File: rtl/clock_mode_controller.sv
// HH:MM:SS time-keeping with a RUN / SET_HOUR / SET_MIN mode FSM and a
// blink phase for the field currently being set.
module clock_mode_controller
   import clock_pkg::*;
#(
   parameter int HOURS_MOD = 24,
   parameter int MIN_MOD   = 60
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick_1hz,
   input  logic              btn_mode,
   input  logic              btn_inc,
   output logic [HOUR_W-1:0] hours,
   output logic [MIN_W-1:0]  minutes,
   output logic [SEC_W-1:0]  seconds,
   output logic [1:0]        mode,
   output logic              blink
);

   clk_mode_t mode_q;
   clk_mode_t mode_d;
   logic      blink_q;
   logic      blink_d;

   logic sec_inc;
   logic sec_clear;
   logic sec_carry;
   logic min_inc;
   logic min_carry;
   logic hour_inc;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q  <= RUN;
         blink_q <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         blink_q <= blink_d;
      end
   end

   // Next-state logic; any unreachable encoding falls back to RUN.
   always_comb begin
      mode_d = mode_q;
      case (mode_q)
         RUN:      if (btn_mode) mode_d = SET_HOUR;
         SET_HOUR: if (btn_mode) mode_d = SET_MIN;
         SET_MIN:  if (btn_mode) mode_d = RUN;
         default:  mode_d = RUN;
      endcase
   end

   // Output logic: counter enables and blink phase.
   // btn_mode pre-empts btn_inc in set modes, and leaving SET_MIN swallows the tick.
   always_comb begin
      sec_inc   = 1'b0;
      sec_clear = 1'b0;
      min_inc   = 1'b0;
      hour_inc  = 1'b0;
      blink_d   = 1'b0;
      case (mode_q)
         RUN: begin
            sec_inc  = tick_1hz;
            min_inc  = sec_carry;
            hour_inc = min_carry;
            blink_d  = btn_mode;
         end
         SET_HOUR: begin
            hour_inc = btn_inc && !btn_mode;
            if (btn_mode) begin
               blink_d = 1'b1;
            end else begin
               blink_d = blink_q ^ tick_1hz;
            end
         end
         SET_MIN: begin
            min_inc = btn_inc && !btn_mode;
            if (btn_mode) begin
               sec_clear = 1'b1;
               blink_d   = 1'b0;
            end else begin
               blink_d = blink_q ^ tick_1hz;
            end
         end
         default: begin
            blink_d = 1'b0;
         end
      endcase
   end

   mod_counter #(.WIDTH(SEC_W), .MOD(MIN_MOD)) u_sec (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (sec_inc),
      .clear (sec_clear),
      .value (seconds),
      .carry (sec_carry)
   );

   mod_counter #(.WIDTH(MIN_W), .MOD(MIN_MOD)) u_min (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (min_inc),
      .clear (1'b0),
      .value (minutes),
      .carry (min_carry)
   );

   // Day wrap has no consumer; the hours carry is left open.
   mod_counter #(.WIDTH(HOUR_W), .MOD(HOURS_MOD)) u_hour (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (hour_inc),
      .clear (1'b0),
      .value (hours),
      .carry ()
   );

   assign mode  = mode_q;
   assign blink = blink_q;

endmodule

// File: tb/tb_clock_mode_controller.sv
// Directed bench for clock_mode_controller: a behavioural model pushes the
// expected state per driven cycle, popped and compared one clock later.
module tb_clock_mode_controller;

   logic       clk;
   logic       rst_n;
   logic       tick_1hz;
   logic       btn_mode;
   logic       btn_inc;
   logic [4:0] hours;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic [1:0] mode;
   logic       blink;

   int errors = 0;
   int checks = 0;
   int step_no = 0;

   typedef struct {
      int h;
      int m;
      int s;
      int md;
      int b;
   } exp_t;

   exp_t exp_q[$];

   // Reference model state
   int m_h = 0;
   int m_m = 0;
   int m_s = 0;
   int m_md = 0;
   int m_b = 0;

   clock_mode_controller #(.HOURS_MOD(24), .MIN_MOD(60)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_1hz (tick_1hz),
      .btn_mode (btn_mode),
      .btn_inc  (btn_inc),
      .hours    (hours),
      .minutes  (minutes),
      .seconds  (seconds),
      .mode     (mode),
      .blink    (blink)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Model one clock of behaviour using total-seconds arithmetic in RUN.
   task automatic model(input bit t, input bit bm, input bit bi);
      int total;
      case (m_md)
         0: begin
            if (t) begin
               total = (m_h * 3600 + m_m * 60 + m_s + 1) % (24 * 3600);
               m_h = total / 3600;
               m_m = (total / 60) % 60;
               m_s = total % 60;
            end
            m_b  = bm ? 1 : 0;
            m_md = bm ? 1 : 0;
         end
         1: begin
            if (bm) begin
               m_md = 2;
               m_b  = 1;
            end else begin
               if (bi) m_h = (m_h + 1) % 24;
               if (t)  m_b = 1 - m_b;
            end
         end
         default: begin
            if (bm) begin
               m_md = 0;
               m_s  = 0;
               m_b  = 0;
            end else begin
               if (bi) m_m = (m_m + 1) % 60;
               if (t)  m_b = 1 - m_b;
            end
         end
      endcase
   endtask

   // Drive one cycle of inputs, push the expectation, compare after the edge.
   task automatic step(input bit t, input bit bm, input bit bi);
      exp_t e;
      tick_1hz = t;
      btn_mode = bm;
      btn_inc  = bi;
      model(t, bm, bi);
      e.h = m_h; e.m = m_m; e.s = m_s; e.md = m_md; e.b = m_b;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      tick_1hz = 1'b0;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      e = exp_q.pop_front();
      step_no++;
      $display("step %0d: tick=%0b mode_btn=%0b inc=%0b -> %0d:%0d:%0d mode=%0d blink=%0b",
               step_no, t, bm, bi, hours, minutes, seconds, mode, blink);
      check("hours",   32'(hours),   32'(e.h));
      check("minutes", 32'(minutes), 32'(e.m));
      check("seconds", 32'(seconds), 32'(e.s));
      check("mode",    32'(mode),    32'(e.md));
      check("blink",   32'(blink),   32'(e.b));
   endtask

   task automatic repeat_step(input int n, input bit t, input bit bm, input bit bi);
      for (int i = 0; i < n; i++) step(t, bm, bi);
   endtask

   initial begin
      rst_n    = 1'b0;
      tick_1hz = 1'b0;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_hours", 32'(hours), 0);
      check("reset_mode",  32'(mode),  0);
      check("reset_blink", 32'(blink), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 61 seconds of RUN
      repeat_step(61, 1'b1, 1'b0, 1'b0);
      check("run61_min", 32'(minutes), 1);
      check("run61_sec", 32'(seconds), 1);

      // Preload 23:59:58, then roll the day over
      step(1'b0, 1'b1, 1'b0);
      repeat_step(23, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      repeat_step(58, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      check("preload_sec_clr", 32'(seconds), 0);
      repeat_step(58, 1'b1, 1'b0, 1'b0);
      check("preload_hours", 32'(hours), 23);
      check("preload_min",   32'(minutes), 59);
      repeat_step(2, 1'b1, 1'b0, 1'b0);
      check("rollover_h", 32'(hours), 0);
      check("rollover_m", 32'(minutes), 0);
      check("rollover_s", 32'(seconds), 0);

      // Set hours to 5, minutes through wrap to 1
      step(1'b0, 1'b1, 1'b0);
      check("enter_set_blink", 32'(blink), 1);
      repeat_step(5, 1'b0, 1'b0, 1'b1);
      check("set_hours5", 32'(hours), 5);
      step(1'b0, 1'b1, 1'b0);
      repeat_step(61, 1'b0, 1'b0, 1'b1);
      check("set_min_wrap", 32'(minutes), 1);
      check("set_min_mode", 32'(mode), 2);
      step(1'b0, 1'b1, 1'b0);
      check("exit_mode", 32'(mode), 0);

      // btn_mode beats btn_inc; blink toggles on ticks in SET_MIN
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      check("mode_wins_hours", 32'(hours), 5);
      check("mode_wins_mode",  32'(mode), 2);
      check("blink_t0", 32'(blink), 1);
      step(1'b1, 1'b0, 1'b0);
      check("blink_t1", 32'(blink), 0);
      step(1'b1, 1'b0, 1'b0);
      check("blink_t2", 32'(blink), 1);
      step(1'b1, 1'b0, 1'b0);
      check("blink_t3", 32'(blink), 0);
      check("frozen_sec", 32'(seconds), 0);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      check("exit_tick_sec", 32'(seconds), 0);

      // Tick and btn_mode together at seconds=59
      repeat_step(59, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      check("tick_mode_sec", 32'(seconds), 0);
      check("tick_mode_min", 32'(minutes), 3);
      check("tick_mode_mode", 32'(mode), 1);

      // Asynchronous reset in the middle of SET_MIN
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_hours", 32'(hours), 0);
      check("async_min",   32'(minutes), 0);
      check("async_mode",  32'(mode), 0);
      check("async_blink", 32'(blink), 0);
      m_h = 0; m_m = 0; m_s = 0; m_md = 0; m_b = 0;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      repeat_step(3, 1'b1, 1'b0, 1'b0);
      check("resume_sec", 32'(seconds), 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/clock_mode_controller.md
Name: clock_mode_controller

Overview:
- Time-keeping and set-mode controller for the digital clock.
- Consumes the 1 Hz single-cycle tick from the clock divider and two debounced single-cycle button pulses.
- Sequences the HH:MM:SS counters through run and set modes.
- Drives binary time fields plus a blink flag to the display/BCD stage downstream.

Parameters:
- HOURS_MOD, 24, hour field modulus; hours wrap HOURS_MOD-1 -> 0. Legal values: 12 or 24.
- MIN_MOD, 60, minute modulus. Also used as the seconds modulus.

Ports:
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  asynchronous active-low reset
- tick_1hz  in  1  one-cycle pulse, once per second
- btn_mode  in  1  one-cycle pulse (debounced upstream), advances mode
- btn_inc  in  1  one-cycle pulse (debounced upstream), increments selected field
- hours  out  5  current hours, binary, 0..HOURS_MOD-1
- minutes  out  6  current minutes, binary, 0..59
- seconds  out  6  current seconds, binary, 0..59
- mode  out  2  current state encoding (RUN=0, SET_HOUR=1, SET_MIN=2)
- blink  out  1  display blink phase for the field being set

Behaviour:
- Reset (async assert, any time, including mid-set):
  - hours=0, minutes=0, seconds=0.
  - mode=RUN, blink=0.
  - Release is synchronous to clk.
- All outputs are registered. Effect of an input pulse appears on the outputs the cycle after the pulse.
- FSM transitions:
  - RUN --btn_mode--> SET_HOUR --btn_mode--> SET_MIN --btn_mode--> RUN.
  - No other transitions.
- RUN:
  - On tick_1hz: seconds+1.
  - seconds 59 -> 0 carries into minutes.
  - minutes 59 -> 0 carries into hours.
  - hours HOURS_MOD-1 -> 0.
  - Full rollover 23:59:59 -> 00:00:00 happens in a single cycle.
  - btn_inc is ignored. blink is held at 0.
- SET_HOUR / SET_MIN:
  - Seconds are frozen; tick_1hz does not advance time.
  - btn_inc increments only the selected field, with wrap: hours HOURS_MOD-1 -> 0, minutes 59 -> 0.
  - No carry into other fields.
  - blink toggles on every tick_1hz.
- Entering SET_HOUR: blink is set to 1.
- Transition SET_HOUR -> SET_MIN: blink is set to 1.
- Transition SET_MIN -> RUN: seconds cleared to 0, blink cleared to 0.
- Simultaneous events:
  - tick_1hz and btn_mode in RUN, same cycle: the tick increment is applied AND the state moves to SET_HOUR.
  - btn_mode and btn_inc in a set state, same cycle: btn_mode wins; the increment is discarded.
  - tick_1hz and btn_inc in a set state, same cycle: the increment is applied and blink toggles.
  - btn_mode and tick_1hz in SET_MIN, same cycle: go to RUN with seconds=0. The tick is not counted.
- Back-to-back pulses on consecutive cycles are each honoured; no minimum spacing.
- Width rules:
  - Field increments are computed in field width.
  - Compare against modulus-1 before adding; never rely on natural overflow.
- Illegal mode encoding 3 (not reachable): recover to RUN on the next clk.

Decomposition:
- Shared package clock_pkg holds:
  - typedef enum logic [1:0] clk_mode_t {RUN, SET_HOUR, SET_MIN}.
  - Localparams for field widths (HOUR_W=5, MIN_W=6, SEC_W=6).
- One natural sub-module: mod_counter.
  - Parameterised WIDTH and MOD.
  - Inputs inc, clear. Outputs value and carry (carry = inc && value==MOD-1, combinational).
  - Instantiated three times.
  - The controller gates each instance's inc from the FSM state and carries.

Test Plan:
- Reset, then 61 tick_1hz pulses in RUN -> 00:01:01; mode=0; blink=0 throughout.
- Preload 23:59:58 via set mode (SET_MIN exit clears seconds; then 58 ticks), then 2 ticks -> 00:00:00 on the cycle after the second tick.
- btn_mode, then 5 btn_inc -> hours=5, mode=1. btn_mode, then 61 btn_inc -> minutes=1 (wrap 59->0->1), mode=2, hours still 5. btn_mode -> mode=0, seconds=0.
- In SET_HOUR, btn_mode and btn_inc on the same cycle -> mode=2, hours unchanged. In SET_MIN, 3 ticks -> blink 1,0,1,0 sequence and seconds unchanged.
- In RUN at seconds=59, tick_1hz and btn_mode on the same cycle -> seconds=0, minutes+1, mode=1.
- Assert rst_n low mid-SET_MIN, asynchronously (not clock-aligned) -> outputs zero immediately, before the next clk edge. After release, mode=0 and time resumes counting from 00:00:00.
